// File: rtl/load_store_unit.sv
// load_store_unit: formats loads/stores for a single-outstanding word bus.
// Ports: clk, rst (async active-low), Load/Store one-hot commands, Addr,
//   WriteData; bus side mem_req/we/addr/wdata/wstrb, mem_rdata, mem_ack;
//   core side ReadData, Stall, Done, Misaligned.
// Option: define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Load,
  input  logic [2:0]  Store,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic        Misaligned
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  ld_q, ld_d;
  logic [1:0]  lane_q, lane_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  logic [31:0] read_data_q, read_data_d;
  logic        done_q, done_d;
  logic        cmd_valid;
  logic        mis;

  assign cmd_valid = $onehot({Load, Store});

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q, mis_d;

  assign mis = ((Load[1] | Load[4] | Store[1]) & Addr[0])
             | ((Load[2] | Store[2]) & (|Addr[1:0]));
  assign Misaligned = mis_q;
`else
  assign mis = 1'b0;
  assign Misaligned = 1'b0;
`endif

  function automatic logic [31:0] fmt_load(
    input logic [4:0]  ld,
    input logic [1:0]  lane,
    input logic [31:0] rdata
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = 8'(rdata >> {lane, 3'b000});
    h = lane[1] ? rdata[31:16] : rdata[15:0];
    r = rdata;
    unique case (1'b1)
      ld[0]:   r = {{24{b[7]}}, b};
      ld[1]:   r = {{16{h[15]}}, h};
      ld[2]:   r = rdata;
      ld[3]:   r = {24'h0, b};
      ld[4]:   r = {16'h0, h};
      default: r = rdata;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    ld_d        = ld_q;
    lane_d      = lane_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    read_data_d = read_data_q;
    done_d      = done_q;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_d       = mis_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          ld_d   = Load;
          lane_d = Addr[1:0];
          if (mis) begin
            // Trap: skip the bus and report straight away.
            state_d = RESP;
            done_d  = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
            mis_d   = 1'b1;
`endif
          end else begin
            state_d     = ACCESS;
            mem_req_d   = 1'b1;
            mem_we_d    = |Store;
            mem_addr_d  = {Addr[31:2], 2'b00};
            mem_wdata_d = 32'h0;
            mem_wstrb_d = 4'h0;
            unique case (1'b1)
              Store[0]: begin
                mem_wdata_d = {4{WriteData[7:0]}};
                mem_wstrb_d = 4'b0001 << Addr[1:0];
              end
              Store[1]: begin
                mem_wdata_d = {2{WriteData[15:0]}};
                mem_wstrb_d = 4'b0011 << {Addr[1], 1'b0};
              end
              Store[2]: begin
                mem_wdata_d = WriteData;
                mem_wstrb_d = 4'b1111;
              end
              default: begin
                mem_wdata_d = 32'h0;
                mem_wstrb_d = 4'h0;
              end
            endcase
          end
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d     = RESP;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_wstrb_d = 4'h0;
          done_d      = 1'b1;
          if (|ld_q) begin
            read_data_d = fmt_load(ld_q, lane_q, mem_rdata);
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        done_d  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      ld_q        <= 5'h0;
      lane_q      <= 2'h0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 32'h0;
      mem_wdata_q <= 32'h0;
      mem_wstrb_q <= 4'h0;
      read_data_q <= 32'h0;
      done_q      <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ld_q        <= ld_d;
      lane_q      <= lane_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      read_data_q <= read_data_d;
      done_q      <= done_d;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q       <= mis_d;
`endif
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign ReadData  = read_data_q;
  assign Done      = done_q;

  // Gated by rst so a command present during reset never stalls the core.
  assign Stall = rst & (((state_q == IDLE) & cmd_valid)
                        | (state_q == ACCESS));

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed + randomized checks of load_store_unit
// against a behavioural load/store model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Load;
  logic [2:0]  Store;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Done;
  logic        Misaligned;

  int total = 0;
  int bad = 0;
  logic [31:0] rd_model;

  load_store_unit dut (
    .clk(clk), .rst(rst), .Load(Load), .Store(Store),
    .Addr(Addr), .WriteData(WriteData),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .ReadData(ReadData), .Stall(Stall), .Done(Done),
    .Misaligned(Misaligned)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // kinds: 0 LB 1 LH 2 LW 3 LBU 4 LHU 5 SB 6 SH 7 SW
  function automatic bit is_mis(input int k, input logic [31:0] a);
`ifdef LSU_MISALIGN_TRAP_EN
    if (k == 1 || k == 4 || k == 6) return (a % 2) != 0;
    if (k == 2 || k == 7) return (a % 4) != 0;
    return 0;
`else
    return (k < 0) && (a == 0);
`endif
  endfunction

  function automatic logic [31:0] exp_load(input int k,
      input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * (a % 4))) & 32'hFF;
    h = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
    case (k)
      0: return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      1: return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      2: return rd;
      3: return b;
      default: return h;
    endcase
  endfunction

  function automatic logic [31:0] exp_wstrb(input int k,
      input logic [31:0] a);
    case (k)
      5: return 32'd1 << (a % 4);
      6: return 32'd3 << (2 * ((a / 2) % 2));
      7: return 32'd15;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input int k,
      input logic [31:0] wd);
    case (k)
      5: return (wd & 32'hFF) * 32'h0101_0101;
      6: return (wd & 32'hFFFF) * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  task automatic set_cmd(input int k);
    Load  = (k < 5) ? 5'(1 << k) : 5'h0;
    Store = (k >= 5) ? 3'(1 << (k - 5)) : 3'h0;
  endtask

  task automatic txn(input int k, input logic [31:0] a,
      input logic [31:0] wd, input logic [31:0] rd, input int waits,
      input bit cmd_in_resp, output int stall_cyc);
    stall_cyc = 0;
    @(negedge clk);
    set_cmd(k);
    Addr = a;
    WriteData = wd;
    #1 check("stall_cmd", 32'(Stall), 32'd1);
    @(negedge clk);
    Load = 5'h0;
    Store = 3'h0;
    if (is_mis(k, a)) begin
      check("mis_req", 32'(mem_req), 32'd0);
      check("mis_done", 32'(Done), 32'd1);
      check("mis_flag", 32'(Misaligned), 32'd1);
      check("mis_stall", 32'(Stall), 32'd0);
      check("mis_rdata", ReadData, rd_model);
      @(negedge clk);
      check("mis_done_off", 32'(Done), 32'd0);
      check("mis_flag_off", 32'(Misaligned), 32'd0);
      return;
    end
    for (int w = 0; w <= waits; w++) begin
      check("req", 32'(mem_req), 32'd1);
      check("we", 32'(mem_we), (k >= 5) ? 32'd1 : 32'd0);
      check("addr", mem_addr, a & ~32'd3);
      check("wstrb", 32'(mem_wstrb), exp_wstrb(k, a));
      if (k >= 5) check("wdata", mem_wdata, exp_wdata(k, wd));
      if (Stall) stall_cyc++;
      mem_ack = (w == waits);
      mem_rdata = (w == waits) ? rd : $urandom;
      @(negedge clk);
    end
    mem_ack = 1'b0;
    mem_rdata = $urandom;
    if (k < 5) rd_model = exp_load(k, a, rd);
    check("done", 32'(Done), 32'd1);
    check("mis_off", 32'(Misaligned), 32'd0);
    check("req_off", 32'(mem_req), 32'd0);
    check("stall_resp", 32'(Stall), 32'd0);
    check("rdata", ReadData, rd_model);
    if (cmd_in_resp) begin
      set_cmd(2);
      Addr = 32'h0;
      #1 check("stall_resp_cmd", 32'(Stall), 32'd0);
    end
    @(negedge clk);
    Load = 5'h0;
    Store = 3'h0;
    check("done_off", 32'(Done), 32'd0);
    check("idle_req", 32'(mem_req), 32'd0);
  endtask

  task automatic invalid_cmd(input logic [4:0] ld, input logic [2:0] st);
    @(negedge clk);
    Load = ld;
    Store = st;
    #1 check("inv_stall", 32'(Stall), 32'd0);
    @(negedge clk);
    check("inv_req", 32'(mem_req), 32'd0);
    check("inv_done", 32'(Done), 32'd0);
    #1 check("inv_stall2", 32'(Stall), 32'd0);
    Load = 5'h0;
    Store = 3'h0;
  endtask

  task automatic idle_ack();
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("idle_ack_done", 32'(Done), 32'd0);
    check("idle_ack_req", 32'(mem_req), 32'd0);
  endtask

  initial begin
    int sc;
    rst = 1'b0;
    Load = 5'h0;
    Store = 3'h0;
    Addr = 32'h0;
    WriteData = 32'h0;
    mem_rdata = 32'h0;
    mem_ack = 1'b0;
    rd_model = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", mem_addr, 32'd0);
    check("rst_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_rdata", ReadData, 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_stall", 32'(Stall), 32'd0);
    #1 rst = 1'b1;

    txn(0, 32'h103, 32'h0, 32'h80FF_0000, 2, 0, sc);
    check("lb_value", ReadData, 32'hFFFF_FF80);
    check("lb_stall_cycles", 32'(sc), 32'd3);

    txn(6, 32'h202, 32'h1234_ABCD, 32'h0, 0, 0, sc);

    txn(4, 32'h2, 32'h0, 32'h8001_7FFF, 1, 0, sc);
    check("lhu_value", ReadData, 32'h0000_8001);
    txn(7, 32'h10, 32'hDEAD_BEEF, 32'h5555_5555, 0, 1, sc);
    check("sw_keeps_rdata", ReadData, 32'h0000_8001);

    invalid_cmd(5'b00001, 3'b001);
    idle_ack();

    // Reset in the middle of an access.
    @(negedge clk);
    set_cmd(2);
    Addr = 32'h40;
    @(negedge clk);
    Load = 5'h0;
    check("abort_req_before", 32'(mem_req), 32'd1);
    #2 rst = 1'b0;
    #1 check("abort_req", 32'(mem_req), 32'd0);
    check("abort_stall", 32'(Stall), 32'd0);
    check("abort_done", 32'(Done), 32'd0);
    check("abort_rdata", ReadData, 32'd0);
    rd_model = 32'h0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    check("abort_done2", 32'(Done), 32'd0);
    #1 rst = 1'b1;
    txn(2, 32'h44, 32'h0, 32'hCAFE_F00D, 1, 0, sc);
    check("lw_after_rst", ReadData, 32'hCAFE_F00D);

    txn(2, 32'h6, 32'h0, 32'h1357_9BDF, 0, 0, sc);
`ifdef LSU_MISALIGN_TRAP_EN
    check("lw_mis_keep", ReadData, 32'hCAFE_F00D);
`else
    check("lw_unaligned", ReadData, 32'h1357_9BDF);
`endif

    for (int n = 0; n < 300; n++) begin
      int k, r;
      k = int'($urandom_range(0, 7));
      txn(k, $urandom, $urandom, $urandom, int'($urandom_range(0, 3)),
          bit'($urandom_range(0, 1)), sc);
      r = int'($urandom_range(0, 9));
      if (r == 0) idle_ack();
      if (r == 1) begin
        int i, j;
        logic [7:0] v;
        i = int'($urandom_range(0, 7));
        j = (i + int'($urandom_range(1, 7))) % 8;
        v = 8'((1 << i) | (1 << j));
        invalid_cmd(v[4:0], v[7:5]);
      end
      if (r == 2) invalid_cmd(5'h0, 3'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=%0d exp=%0d", 0, 1);
    $fatal(1);
  end

endmodule
